// File: rtl/divider_pkg.sv
// Shared definitions for the divider: FSM state encoding and default operand width.
// Used by divider (top) and div_step; DIVIDER_SIGNED_EN selects the signed build in the top.
package divider_pkg;

   localparam int unsigned DIV_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/divider_div_step.sv
// One restoring-division iteration: shift in the next dividend bit, subtract the
// divisor if it fits, emit the quotient bit.
module div_step
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic [WIDTH-1:0] i_rem,
   input  logic             i_bit,
   input  logic [WIDTH-1:0] i_divisor,
   output logic [WIDTH-1:0] o_rem,
   output logic             o_qbit
);

   logic [WIDTH:0]   w_shift;
   logic [WIDTH-1:0] w_diff;

   // The partial remainder stays below the divisor, so the low WIDTH bits of the
   // difference are exact whenever the subtraction is taken.
   always_comb begin
      w_shift = {i_rem, i_bit};
      w_diff  = w_shift[WIDTH-1:0] - i_divisor;
      o_qbit  = (w_shift >= {1'b0, i_divisor});
      o_rem   = o_qbit ? w_diff : w_shift[WIDTH-1:0];
   end

endmodule

// File: rtl/divider.sv
// Iterative restoring divider, one quotient bit per cycle, result = {remainder, quotient}.
// Define DIVIDER_SIGNED_EN for two's-complement operands; default build is unsigned.
module divider
   import divider_pkg::*;
#(
   parameter int unsigned WIDTH = DIV_WIDTH
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic [WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]   divisor,
   input  logic               op_start,
   input  logic               op_clear,
   output logic               op_done,
   output logic [2*WIDTH-1:0] result,
   output logic               div_by_zero
);

   localparam int unsigned      CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIDTH);

   state_t             r_state, w_state_nxt;
   logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
   logic [WIDTH-1:0]   r_rem, w_rem_nxt;
   logic [WIDTH-1:0]   r_quo, w_quo_nxt;
   logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
   logic [2*WIDTH-1:0] r_result, w_result_nxt;
   logic               r_dbz, w_dbz_nxt;

   logic [WIDTH-1:0]   w_step_rem;
   logic               w_step_qbit;
   logic [WIDTH-1:0]   w_dvd_mag, w_dvs_mag;
   logic [WIDTH-1:0]   w_quo_fin, w_rem_fin, w_dvd_orig;

`ifdef DIVIDER_SIGNED_EN
   logic r_neg_q, w_neg_q_nxt;
   logic r_neg_r, w_neg_r_nxt;

   // Iterate on magnitudes; signs are restored once the last bit is in.
   assign w_dvd_mag  = dividend[WIDTH-1] ? -dividend : dividend;
   assign w_dvs_mag  = divisor[WIDTH-1] ? -divisor : divisor;
   assign w_quo_fin  = r_neg_q ? -r_quo : r_quo;
   assign w_rem_fin  = r_neg_r ? -r_rem : r_rem;
   assign w_dvd_orig = r_neg_r ? -r_quo : r_quo;
`else
   assign w_dvd_mag  = dividend;
   assign w_dvs_mag  = divisor;
   assign w_quo_fin  = r_quo;
   assign w_rem_fin  = r_rem;
   assign w_dvd_orig = r_quo;
`endif

   div_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .i_rem     (r_rem),
      .i_bit     (r_quo[WIDTH-1]),
      .i_divisor (r_dvs),
      .o_rem     (w_step_rem),
      .o_qbit    (w_step_qbit)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_nxt    = r_cnt;
      w_rem_nxt    = r_rem;
      w_quo_nxt    = r_quo;
      w_dvs_nxt    = r_dvs;
      w_result_nxt = r_result;
      w_dbz_nxt    = r_dbz;
`ifdef DIVIDER_SIGNED_EN
      w_neg_q_nxt  = r_neg_q;
      w_neg_r_nxt  = r_neg_r;
`endif
      if (op_clear) begin
         w_state_nxt  = IDLE;
         w_cnt_nxt    = '0;
         w_result_nxt = '0;
         w_dbz_nxt    = 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (op_start) begin
                  w_quo_nxt   = w_dvd_mag;
                  w_dvs_nxt   = w_dvs_mag;
                  w_rem_nxt   = '0;
                  w_cnt_nxt   = '0;
`ifdef DIVIDER_SIGNED_EN
                  w_neg_q_nxt = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                  w_neg_r_nxt = dividend[WIDTH-1];
`endif
                  w_state_nxt = EXEC;
               end
            end
            EXEC: begin
               if (r_dvs == '0) begin
                  w_result_nxt = {w_dvd_orig, {WIDTH{1'b1}}};
                  w_dbz_nxt    = 1'b1;
                  w_state_nxt  = DONE;
               end else if (r_cnt == LAST) begin
                  w_result_nxt = {w_rem_fin, w_quo_fin};
                  w_state_nxt  = DONE;
               end else begin
                  w_rem_nxt = w_step_rem;
                  w_quo_nxt = {r_quo[WIDTH-2:0], w_step_qbit};
                  w_cnt_nxt = r_cnt + 1'b1;
               end
            end
            DONE: ;
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_result <= '0;
         r_dbz    <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
`endif
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_rem    <= w_rem_nxt;
         r_quo    <= w_quo_nxt;
         r_dvs    <= w_dvs_nxt;
         r_result <= w_result_nxt;
         r_dbz    <= w_dbz_nxt;
`ifdef DIVIDER_SIGNED_EN
         r_neg_q  <= w_neg_q_nxt;
         r_neg_r  <= w_neg_r_nxt;
`endif
      end
   end

   assign op_done     = (r_state == DONE);
   assign result      = r_result;
   assign div_by_zero = r_dbz;

endmodule
